// File: rtl/irq_source_if.sv
// CPU-side interrupt handshake: request line and cause code out, sampling tick and acknowledge in.
interface irq_source_if;
    logic       ncycle;
    logic       ack;
    logic       irq;
    logic [3:0] cause;

    modport master (
        input  ncycle,
        input  ack,
        output irq,
        output cause
    );

    modport slave (
        output ncycle,
        output ack,
        input  irq,
        input  cause
    );
endinterface

// File: rtl/irq_source.sv
// Peripheral interrupt requester: sticky edge-detected pending bits, mask, lowest-index priority,
// one request held until acknowledged, then a tick-counted low gap before the next request.
module irq_source #(
    parameter int NSRC = 4,
    parameter int GAP  = 2
) (
    input  logic            clk,
    input  logic            rst,
    irq_source_if.master    cpu,
    input  logic [NSRC-1:0] src,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_d,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask
);

    localparam int CW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cause_q, cause_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] en_mask_q, en_mask_d;
    logic [NSRC-1:0] hist_q, hist_d;
    logic [CW-1:0]   gap_q, gap_d;
    logic            irq_q, irq_d;

    logic [NSRC-1:0] event_vec;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] clear_vec;
    logic [3:0]      first_idx;
    logic            any_eligible;

    assign event_vec    = src & ~hist_q;
    assign eligible     = pending_q & en_mask_q;
    assign any_eligible = |eligible;

    // Scan downwards so the lowest set index is the one left standing.
    always_comb begin
        first_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                first_idx = 4'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        gap_d     = gap_q;
        clear_vec = '0;
        case (state_q)
            S_IDLE: begin
                if (any_eligible) begin
                    cause_d = first_idx;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (cpu.ack) begin
                    for (int i = 0; i < NSRC; i++) begin
                        if (4'(i) == cause_q) begin
                            clear_vec[i] = 1'b1;
                        end
                    end
                    gap_d   = CW'(GAP);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else if (cpu.ncycle) begin
                    gap_d = gap_q - CW'(1);
                    if (gap_q == CW'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A new event on the source being cleared outranks the clear.
    always_comb begin
        pending_d = (pending_q & ~clear_vec) | event_vec;
        en_mask_d = mask_we ? mask_d : en_mask_q;
        hist_d    = src;
        irq_d     = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cause_q   <= '0;
            pending_q <= '0;
            en_mask_q <= '0;
            hist_q    <= '1;
            gap_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            pending_q <= pending_d;
            en_mask_q <= en_mask_d;
            hist_q    <= hist_d;
            gap_q     <= gap_d;
            irq_q     <= irq_d;
        end
    end

    assign cpu.irq   = irq_q;
    assign cpu.cause = cause_q;
    assign pending   = pending_q;
    assign mask      = en_mask_q;

endmodule

// File: tb/tb_irq_source.sv
// Directed bench for irq_source: expectations queued with each stimulus step, compared one edge later.
module tb_irq_source;

    typedef enum logic [1:0] {
        SEL_IRQ,
        SEL_CAUSE,
        SEL_PEND,
        SEL_MASK
    } sel_t;

    typedef struct {
        sel_t        sel;
        logic [15:0] val;
        string       tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src;
    logic       mask_we;
    logic [3:0] mask_d;
    logic [3:0] pending;
    logic [3:0] mask;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    irq_source_if cpu_if ();

    irq_source #(
        .NSRC(4),
        .GAP (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cpu    (cpu_if),
        .src    (src),
        .mask_we(mask_we),
        .mask_d (mask_d),
        .pending(pending),
        .mask   (mask)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] get_obs(input sel_t sel);
        case (sel)
            SEL_IRQ:   return {15'b0, cpu_if.irq};
            SEL_CAUSE: return {12'b0, cpu_if.cause};
            SEL_PEND:  return {12'b0, pending};
            default:   return {12'b0, mask};
        endcase
    endfunction

    task automatic expect_out(input sel_t sel, input logic [15:0] val, input string tag);
        exp_t e;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_output();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = get_obs(e.sel);
            checks++;
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic idle_out(input string tag);
        for (int k = 0; k < 3; k++) begin
            expect_out(SEL_IRQ, 16'd0, tag);
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seq [5];
        seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b0; src = '0; mask_we = 1'b0; mask_d = '0;
        cpu_if.ack = 1'b0; cpu_if.ncycle = 1'b1;
        #1;
        expect_out(SEL_IRQ, 16'd0, "rst_irq");
        expect_out(SEL_CAUSE, 16'd0, "rst_cause");
        expect_out(SEL_PEND, 16'd0, "rst_pend");
        expect_out(SEL_MASK, 16'd0, "rst_mask");
        check_output();
        step(); step();
        rst = 1'b1;
        step();

        // Single request on src[2]
        mask_we = 1'b1; mask_d = 4'hF;
        expect_out(SEL_MASK, 16'hF, "t1_mask");
        step(); mask_we = 1'b0;
        src = 4'b0100;
        expect_out(SEL_PEND, 16'h4, "t1_pend_set");
        expect_out(SEL_IRQ, 16'd0, "t1_irq_e0");
        step(); src = '0;
        expect_out(SEL_IRQ, 16'd1, "t1_irq_e1");
        expect_out(SEL_CAUSE, 16'd2, "t1_cause");
        step();
        expect_out(SEL_IRQ, 16'd1, "t1_hold");
        step();
        cpu_if.ack = 1'b1;
        expect_out(SEL_IRQ, 16'd0, "t1_ack_irq");
        expect_out(SEL_PEND, 16'd0, "t1_ack_pend");
        step(); cpu_if.ack = 1'b0;
        idle_out("t1_quiet");
        cpu_if.ack = 1'b1;
        expect_out(SEL_IRQ, 16'd0, "stray_ack_irq");
        expect_out(SEL_PEND, 16'd0, "stray_ack_pend");
        step(); cpu_if.ack = 1'b0;

        // Priority and gap timing
        src = 4'b1010;
        expect_out(SEL_PEND, 16'hA, "t2_pend");
        step(); src = '0;
        expect_out(SEL_IRQ, 16'd1, "t2_irq_first");
        expect_out(SEL_CAUSE, 16'd1, "t2_cause_first");
        step();
        cpu_if.ack = 1'b1;
        expect_out(SEL_IRQ, 16'd0, "t2_ack_irq");
        expect_out(SEL_PEND, 16'h8, "t2_ack_pend");
        step();
        expect_out(SEL_IRQ, 16'd0, "t2_gap1");
        step(); cpu_if.ack = 1'b0;
        expect_out(SEL_IRQ, 16'd0, "t2_idle");
        step();
        expect_out(SEL_IRQ, 16'd1, "t2_irq_second");
        expect_out(SEL_CAUSE, 16'd3, "t2_cause_second");
        step();
        cpu_if.ack = 1'b1;
        expect_out(SEL_IRQ, 16'd0, "t2_ack2_irq");
        expect_out(SEL_PEND, 16'd0, "t2_ack2_pend");
        step(); cpu_if.ack = 1'b0;
        idle_out("t2_quiet");

        // Gap gated by ncycle
        src = 4'b0011;
        expect_out(SEL_PEND, 16'h3, "t3_pend");
        step(); src = '0;
        expect_out(SEL_IRQ, 16'd1, "t3_irq_first");
        expect_out(SEL_CAUSE, 16'd0, "t3_cause_first");
        step();
        cpu_if.ack = 1'b1;
        expect_out(SEL_IRQ, 16'd0, "t3_ack_irq");
        expect_out(SEL_PEND, 16'h2, "t3_ack_pend");
        step(); cpu_if.ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cpu_if.ncycle = seq[k];
            expect_out(SEL_IRQ, 16'd0, "t3_gap_low");
            step();
        end
        cpu_if.ncycle = 1'b1;
        expect_out(SEL_IRQ, 16'd1, "t3_irq_second");
        expect_out(SEL_CAUSE, 16'd1, "t3_cause_second");
        step();
        cpu_if.ack = 1'b1;
        expect_out(SEL_PEND, 16'd0, "t3_ack2_pend");
        step(); cpu_if.ack = 1'b0;
        idle_out("t3_quiet");

        // Masking, repeated events, mask write during REQ
        mask_we = 1'b1; mask_d = 4'b0001;
        expect_out(SEL_MASK, 16'h1, "t4_mask1");
        step(); mask_we = 1'b0;
        for (int k = 0; k < 2; k++) begin
            src = 4'b0100;
            expect_out(SEL_PEND, 16'h4, "t4_pend_masked");
            expect_out(SEL_IRQ, 16'd0, "t4_irq_masked");
            step(); src = '0;
            expect_out(SEL_IRQ, 16'd0, "t4_irq_masked2");
            step();
        end
        mask_we = 1'b1; mask_d = 4'b0100;
        expect_out(SEL_MASK, 16'h4, "t4_mask4");
        expect_out(SEL_IRQ, 16'd0, "t4_irq_w");
        step(); mask_we = 1'b0;
        expect_out(SEL_IRQ, 16'd1, "t4_irq_unmasked");
        expect_out(SEL_CAUSE, 16'd2, "t4_cause");
        step();
        mask_we = 1'b1; mask_d = 4'b0000;
        expect_out(SEL_MASK, 16'h0, "t4_mask0");
        expect_out(SEL_IRQ, 16'd1, "t4_irq_kept");
        step(); mask_we = 1'b0;
        expect_out(SEL_CAUSE, 16'd2, "t4_cause_kept");
        expect_out(SEL_IRQ, 16'd1, "t4_irq_kept2");
        step();
        cpu_if.ack = 1'b1;
        expect_out(SEL_IRQ, 16'd0, "t4_ack_irq");
        expect_out(SEL_PEND, 16'd0, "t4_ack_pend");
        step(); cpu_if.ack = 1'b0;
        idle_out("t4_quiet");
        mask_we = 1'b1; mask_d = 4'hF;
        expect_out(SEL_MASK, 16'hF, "t4_maskF");
        step(); mask_we = 1'b0;

        // Event coinciding with ack
        src = 4'b0001;
        expect_out(SEL_PEND, 16'h1, "t5_pend");
        step(); src = '0;
        expect_out(SEL_IRQ, 16'd1, "t5_irq");
        expect_out(SEL_CAUSE, 16'd0, "t5_cause");
        step();
        src = 4'b0001; cpu_if.ack = 1'b1;
        expect_out(SEL_IRQ, 16'd0, "t5_ack_irq");
        expect_out(SEL_PEND, 16'h1, "t5_pend_kept");
        step(); src = '0; cpu_if.ack = 1'b0;
        expect_out(SEL_IRQ, 16'd0, "t5_gap1");
        step();
        expect_out(SEL_IRQ, 16'd0, "t5_idle");
        step();
        expect_out(SEL_IRQ, 16'd1, "t5_rereq");
        expect_out(SEL_CAUSE, 16'd0, "t5_rereq_cause");
        step();
        cpu_if.ack = 1'b1;
        expect_out(SEL_PEND, 16'd0, "t5_ack2_pend");
        step(); cpu_if.ack = 1'b0;
        idle_out("t5_quiet");

        // Reset mid-REQ with src[1] held high
        src = 4'b0010;
        expect_out(SEL_PEND, 16'h2, "t6_pend");
        step();
        expect_out(SEL_IRQ, 16'd1, "t6_irq");
        expect_out(SEL_CAUSE, 16'd1, "t6_cause");
        step();
        rst = 1'b0;
        #1;
        expect_out(SEL_IRQ, 16'd0, "t6_rst_irq");
        expect_out(SEL_CAUSE, 16'd0, "t6_rst_cause");
        expect_out(SEL_PEND, 16'd0, "t6_rst_pend");
        expect_out(SEL_MASK, 16'd0, "t6_rst_mask");
        check_output();
        step();
        rst = 1'b1;
        mask_we = 1'b1; mask_d = 4'hF;
        expect_out(SEL_MASK, 16'hF, "t6_mask");
        expect_out(SEL_PEND, 16'd0, "t6_no_event");
        step(); mask_we = 1'b0;
        for (int k = 0; k < 2; k++) begin
            expect_out(SEL_IRQ, 16'd0, "t6_quiet_irq");
            expect_out(SEL_PEND, 16'd0, "t6_quiet_pend");
            step();
        end
        src = '0;
        expect_out(SEL_PEND, 16'd0, "t6_fall");
        step();
        src = 4'b0010;
        expect_out(SEL_PEND, 16'h2, "t6_rise_pend");
        expect_out(SEL_IRQ, 16'd0, "t6_rise_irq");
        step();
        expect_out(SEL_IRQ, 16'd1, "t6_req_irq");
        expect_out(SEL_CAUSE, 16'd1, "t6_req_cause");
        step();

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_source.md
# irq_source

Peripheral-side interrupt requester that drives the CPU interrupt line `int` and the cause code. It collects rising-edge events from up to NSRC peripheral sources into sticky pending bits and masks them. It presents one request at a time, highest priority first, and holds `int` high until the CPU acknowledges it. Between requests it forces `int` low for a guaranteed number of CPU tick cycles, so that the CPU's repeat-prevention logic sees every new request as a fresh rising level.

## Interface
- NSRC, 4: number of event sources; legal range 1..16.
- GAP, 2: minimum number of tick cycles (`ncycle`=1) during which `int` is held low after an acknowledge; legal range ≥1.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ncycle  input  1  high on CPU interrupt-sampling cycles (not the second cycle of a two-cycle instruction).
- src  input  NSRC  peripheral event lines; a 0→1 transition is one event.
- mask_we  input  1  write enable for the mask register.
- mask_d  input  NSRC  new mask value; 1 = source enabled.
- ack  input  1  single-cycle pulse from the CPU handler: the current request is serviced.
- int  output  1  interrupt request to the CPU.
- cause  output  4  index of the source being requested; valid while `int`=1.
- pending  output  NSRC  raw sticky pending bits, unmasked.
- mask  output  NSRC  current mask register.

## Operation
- Edge detect: `hist` register samples `src` every cycle. An event is `src & ~hist`, and each event sets the corresponding `pending` bit.
- Masking: `eligible = pending & mask`. Priority goes to the lowest index.
- Mask write: `mask <= mask_d` when `mask_we`=1. The new value takes effect from the next cycle.
- State machine states: IDLE, REQ, GAP.
- IDLE:
  - `int`=0.
  - If `eligible`≠0: latch `cause` = lowest set index, then go to REQ.
- REQ:
  - `int`=1 and `cause` is held stable.
  - Mask writes and new events do not withdraw or change the request. This holds even if the requested source becomes masked.
  - On `ack`=1: clear `pending[cause]`, load the gap counter with GAP, then go to GAP.
- GAP:
  - `int`=0.
  - Counter decrements on cycles with `ncycle`=1.
  - When the counter reaches 0, go to IDLE.
  - `ack` is ignored.
- Boundary conditions:
  - **Event and clear in the same cycle:** if an event on `src[cause]` coincides with the ack clear, the event wins and the pending bit stays 1. That source is then re-requested after GAP.
  - **`ack` outside REQ:** no effect.
  - **Multiple simultaneous events:** all set their pending bits. They are serviced one per REQ/GAP round in index order.
  - **Repeated events:** further events on an already-pending source are absorbed (no count).
- Reset, asynchronous, takes effect immediately, including mid-REQ or mid-GAP:
  - state = IDLE, `int`=0, `cause`=0;
  - `pending`=0, `mask`=0, gap counter = 0;
  - `hist` = all 1s, so a source already high at reset release produces no event.

## Timing
- Source to request: `src[i]` is first sampled high at edge E0, which sets `pending[i]`. At edge E1 the block enters REQ. `int` and `cause` are valid after E1, giving 2 cycles of latency when the block is idle and the source is enabled.
- Acknowledge: `ack` is sampled at edge Ea. `int` falls after Ea and the pending bit is cleared at Ea.
- Re-request: `int` stays low for at least GAP cycles with `ncycle`=1. The earliest re-assertion is one cycle after the counter reaches 0, through IDLE.
- If `ncycle` is held 0, GAP never expires and `int` stays low.
- All outputs are registered, with no combinational path from inputs to `int` or `cause`.

## Test plan
- **Reset and single request:** `rst` low then high; `mask`←4'b1111; pulse `src[2]` at cycle 10. Required: `int`=1 from cycle 12 with `cause`=2; `ack` at cycle 15 → `int`=0 at cycle 16 and `pending`=0.
- **Priority and gap:** with `ncycle`=1 constantly, raise `src[3]` and `src[1]` together. Required: `cause`=1 first. After `ack`, `int` is low for exactly 2 cycles plus 1 IDLE cycle, then `int`=1 with `cause`=3.
- **Gap gated by ncycle:** GAP=2; after `ack`, drive `ncycle`=0,1,0,0,1. Required: `int` stays low until after the second `ncycle`=1 cycle, then re-asserts one cycle later.
- **Masking:** `mask`=4'b0001; event on `src[2]`. Required: `int` stays 0 and `pending`=4'b0100. Writing `mask`=4'b0100 → `int`=1 with `cause`=2 two cycles later.
- **Event coinciding with ack:** `src[0]` rises in the same cycle as `ack` for `cause`=0. Required: `pending[0]` remains 1 and `int` re-asserts after the gap with `cause`=0.
- **Reset mid-REQ and high-at-reset:** assert `rst` while `int`=1 with `src[1]` held high. Required: `int`=0 and `pending`=0 immediately. After release, no request occurs until `src[1]` falls and rises again.
